// File: rtl/pauli_pulse_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pauli_pulse_sequencer
// Purpose  : Turns queued Pauli correction commands into timed X/Z drive
//            windows for the qubit controller and keeps run statistics.
// Ports    : clk_1g        - 1 GHz clock
//            rst_n         - asynchronous active-low reset
//            pauli_gate    - correction code (00=I, 01=X, 10=Z, 11=XZ)
//            apply_gate    - one-cycle command strobe
//            teleport_fail - upstream failure level
//            clr_counts    - synchronous clear of all counters
//            drive_x/z     - X / Z drive windows (state decode only)
//            seq_busy      - sequencer active or commands pending
//            seq_done      - one-cycle pulse per completed command
//            seq_overflow  - one-cycle pulse per dropped command
//            gate/drop/fail_count - saturating statistics
// Revision : 1.0 - initial release
// ============================================================================
module pauli_pulse_sequencer #(
  parameter int X_LEN      = 20,
  parameter int Z_LEN      = 8,
  parameter int GAP_LEN    = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clk_1g,
  input  logic                 rst_n,
  input  logic [1:0]           pauli_gate,
  input  logic                 apply_gate,
  input  logic                 teleport_fail,
  input  logic                 clr_counts,
  output logic                 drive_x,
  output logic                 drive_z,
  output logic                 seq_busy,
  output logic                 seq_done,
  output logic                 seq_overflow,
  output logic [CNT_WIDTH-1:0] gate_count,
  output logic [CNT_WIDTH-1:0] drop_count,
  output logic [CNT_WIDTH-1:0] fail_count
);

  localparam int c_MAX_XZ  = (X_LEN > Z_LEN) ? X_LEN : Z_LEN;
  localparam int c_MAX_LEN = (c_MAX_XZ > GAP_LEN) ? c_MAX_XZ : GAP_LEN;
  localparam int c_TW      = (c_MAX_LEN > 1) ? $clog2(c_MAX_LEN) : 1;
  localparam int c_AW      = $clog2(FIFO_DEPTH);

  localparam logic [c_TW-1:0] c_X_LOAD   = c_TW'(X_LEN - 1);
  localparam logic [c_TW-1:0] c_Z_LOAD   = c_TW'(Z_LEN - 1);
  localparam logic [c_TW-1:0] c_GAP_LOAD = c_TW'(GAP_LEN - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_X_PULSE = 3'd1;
  localparam logic [2:0] S_GAP     = 3'd2;
  localparam logic [2:0] S_Z_PULSE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]           r_state;
  logic [2:0]           w_state_nxt;
  logic [c_TW-1:0]      r_timer;
  logic [1:0]           r_code;

  logic [1:0]           r_mem [FIFO_DEPTH];
  logic [c_AW:0]        r_wr_ptr;
  logic [c_AW:0]        r_rd_ptr;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_drop;
  logic [1:0]           w_head;
  logic                 w_tmr_done;

  logic                 r_ovf;
  logic                 r_fail_d1;
  logic                 r_fail_d2;
  logic                 w_fail_rise;
  logic [CNT_WIDTH-1:0] r_gate_cnt;
  logic [CNT_WIDTH-1:0] r_drop_cnt;
  logic [CNT_WIDTH-1:0] r_fail_cnt;

  // --------------------------------------------------------------------------
  // Command FIFO: the extra pointer MSB separates full from empty.
  // --------------------------------------------------------------------------
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                   (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
  assign w_head  = r_mem[r_rd_ptr[c_AW-1:0]];
  assign w_pop   = (r_state == S_IDLE) && !w_empty;
  // A same-cycle pop frees a slot, so a full FIFO can still accept.
  assign w_push  = apply_gate && (!w_full || w_pop);
  assign w_drop  = apply_gate && w_full && !w_pop;

  always_ff @(posedge clk_1g) begin
    if (w_push) begin
      r_mem[r_wr_ptr[c_AW-1:0]] <= pauli_gate;
    end
  end

  always_ff @(posedge clk_1g or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (c_AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (c_AW+1)'(1);
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register, command register and duration timer
  // --------------------------------------------------------------------------
  assign w_tmr_done = (r_timer == '0);

  always_ff @(posedge clk_1g or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_code  <= 2'b00;
    end else begin
      r_state <= w_state_nxt;
      if (w_pop) r_code <= w_head;
      // The timer is reloaded on every state entry with len-1.
      if (w_state_nxt != r_state) begin
        case (w_state_nxt)
          S_X_PULSE: r_timer <= c_X_LOAD;
          S_Z_PULSE: r_timer <= c_Z_LOAD;
          S_GAP:     r_timer <= c_GAP_LOAD;
          default:   r_timer <= '0;
        endcase
      end else if (!w_tmr_done) begin
        r_timer <= r_timer - c_TW'(1);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          case (w_head)
            2'b00:   w_state_nxt = S_DONE;
            2'b10:   w_state_nxt = S_Z_PULSE;
            default: w_state_nxt = S_X_PULSE;
          endcase
        end
      end
      S_X_PULSE: if (w_tmr_done) w_state_nxt = (r_code == 2'b11) ? S_GAP : S_DONE;
      S_GAP:     if (w_tmr_done) w_state_nxt = S_Z_PULSE;
      S_Z_PULSE: if (w_tmr_done) w_state_nxt = S_DONE;
      S_DONE:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Drives are decoded from the state register only, keeping them glitch-free.
  always_comb begin
    drive_x  = (r_state == S_X_PULSE);
    drive_z  = (r_state == S_Z_PULSE);
    seq_done = (r_state == S_DONE);
    seq_busy = (r_state != S_IDLE) || !w_empty;
  end

  // --------------------------------------------------------------------------
  // Statistics
  // --------------------------------------------------------------------------
  assign w_fail_rise = r_fail_d1 && !r_fail_d2;

  always_ff @(posedge clk_1g or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf     <= 1'b0;
      r_fail_d1 <= 1'b0;
      r_fail_d2 <= 1'b0;
    end else begin
      r_ovf     <= w_drop;
      r_fail_d1 <= teleport_fail;
      r_fail_d2 <= r_fail_d1;
    end
  end

  always_ff @(posedge clk_1g or negedge rst_n) begin
    if (!rst_n) begin
      r_gate_cnt <= '0;
      r_drop_cnt <= '0;
      r_fail_cnt <= '0;
    end else if (clr_counts) begin
      r_gate_cnt <= '0;
      r_drop_cnt <= '0;
      r_fail_cnt <= '0;
    end else begin
      if ((r_state == S_DONE) && (r_gate_cnt != '1)) r_gate_cnt <= r_gate_cnt + CNT_WIDTH'(1);
      if (w_drop && (r_drop_cnt != '1))              r_drop_cnt <= r_drop_cnt + CNT_WIDTH'(1);
      if (w_fail_rise && (r_fail_cnt != '1))         r_fail_cnt <= r_fail_cnt + CNT_WIDTH'(1);
    end
  end

  assign seq_overflow = r_ovf;
  assign gate_count   = r_gate_cnt;
  assign drop_count   = r_drop_cnt;
  assign fail_count   = r_fail_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pauli_pulse_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_pauli_pulse_sequencer
// Purpose  : Directed self-checking bench for pauli_pulse_sequencer with a
//            per-cycle timeline model and hand-computed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pauli_pulse_sequencer;

  localparam int X_LEN      = 20;
  localparam int Z_LEN      = 8;
  localparam int GAP_LEN    = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_WIDTH  = 32;

  logic                 clk_1g = 1'b0;
  logic                 rst_n;
  logic [1:0]           pauli_gate;
  logic                 apply_gate;
  logic                 teleport_fail;
  logic                 clr_counts;
  logic                 drive_x;
  logic                 drive_z;
  logic                 seq_busy;
  logic                 seq_done;
  logic                 seq_overflow;
  logic [CNT_WIDTH-1:0] gate_count;
  logic [CNT_WIDTH-1:0] drop_count;
  logic [CNT_WIDTH-1:0] fail_count;

  pauli_pulse_sequencer #(
    .X_LEN(X_LEN), .Z_LEN(Z_LEN), .GAP_LEN(GAP_LEN),
    .FIFO_DEPTH(FIFO_DEPTH), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk_1g(clk_1g), .rst_n(rst_n), .pauli_gate(pauli_gate),
    .apply_gate(apply_gate), .teleport_fail(teleport_fail),
    .clr_counts(clr_counts), .drive_x(drive_x), .drive_z(drive_z),
    .seq_busy(seq_busy), .seq_done(seq_done), .seq_overflow(seq_overflow),
    .gate_count(gate_count), .drop_count(drop_count), .fail_count(fail_count)
  );

  always #5 clk_1g = ~clk_1g;

  int cyc = 0;
  always @(posedge clk_1g) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + CNT_WIDTH'(1);
  endfunction

  // --------------------------------------------------------------------------
  // Model: queued commands plus a per-cycle timeline of the command in flight.
  // Timeline entries are {x, z, done}; an empty timeline means idle.
  // --------------------------------------------------------------------------
  logic [1:0]           m_cq [$];
  logic [2:0]           m_tl [$];
  logic [CNT_WIDTH-1:0] m_gate, m_drop, m_fail;
  logic                 m_ovf, m_f1, m_f2;
  int                   ovf_seen = 0;

  initial begin
    logic [2:0] cur;
    logic       busy, pop, drop;
    logic [1:0] code;
    forever begin
      @(negedge clk_1g);
      if (seq_overflow) ovf_seen++;
      if (!rst_n) begin
        m_cq.delete(); m_tl.delete();
        m_gate = '0; m_drop = '0; m_fail = '0;
        m_ovf = 1'b0; m_f1 = 1'b0; m_f2 = 1'b0;
        check("reset_outs", {drive_x, drive_z, seq_done, seq_overflow, seq_busy}, 5'b0);
        check("reset_counts", {gate_count, drop_count, fail_count}, '0);
      end else begin
        cur  = (m_tl.size() > 0) ? m_tl[0] : 3'b000;
        busy = (m_tl.size() > 0) || (m_cq.size() > 0);
        check("outs{x,z,done,ovf,busy}",
              {drive_x, drive_z, seq_done, seq_overflow, seq_busy},
              {cur, m_ovf, busy});
        check("gate_count", gate_count, m_gate);
        check("drop_count", drop_count, m_drop);
        check("fail_count", fail_count, m_fail);
        pop  = (m_tl.size() == 0) && (m_cq.size() > 0);
        drop = apply_gate && (m_cq.size() == FIFO_DEPTH) && !pop;
        if (cur[0]) m_gate = sat_inc(m_gate);
        if (drop)   m_drop = sat_inc(m_drop);
        if (m_f1 && !m_f2) m_fail = sat_inc(m_fail);
        m_f2 = m_f1;
        m_f1 = teleport_fail;
        if (clr_counts) begin m_gate = '0; m_drop = '0; m_fail = '0; end
        m_ovf = drop;
        if (m_tl.size() > 0) begin
          void'(m_tl.pop_front());
        end else if (pop) begin
          code = m_cq.pop_front();
          if (code[0]) for (int i = 0; i < X_LEN; i++) m_tl.push_back(3'b100);
          if (code == 2'b11) for (int i = 0; i < GAP_LEN; i++) m_tl.push_back(3'b000);
          if (code[1]) for (int i = 0; i < Z_LEN; i++) m_tl.push_back(3'b010);
          m_tl.push_back(3'b001);
        end
        if (apply_gate && !drop) m_cq.push_back(pauli_gate);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic at_cycle(input int n);
    @(negedge clk_1g);
    while (cyc < n) @(negedge clk_1g);
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    @(negedge clk_1g);
    while (seq_busy && k < budget) begin
      @(negedge clk_1g);
      k++;
    end
    check("idle_reached", seq_busy, 1'b0);
  endtask

  task automatic issue(input logic [1:0] code, output int c0);
    @(posedge clk_1g); #1;
    apply_gate = 1'b1;
    pauli_gate = code;
    c0 = cyc;
    @(posedge clk_1g); #1;
    apply_gate = 1'b0;
  endtask

  task automatic pulse_clr();
    @(posedge clk_1g); #1 clr_counts = 1'b1;
    @(posedge clk_1g); #1 clr_counts = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // --------------------------------------------------------------------------
  // Directed tests
  // --------------------------------------------------------------------------
  initial begin
    int c0;
    logic [1:0] seq6 [6];
    seq6 = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10};
    rst_n = 1'b0; apply_gate = 1'b0; pauli_gate = 2'b00;
    teleport_fail = 1'b0; clr_counts = 1'b0;
    repeat (3) @(posedge clk_1g);
    #1 rst_n = 1'b1;

    // Single X: drive_x cycles 2..21, seq_done at 22
    issue(2'b01, c0);
    at_cycle(c0 + 1);  check("x_pre",      drive_x, 1'b0);
    at_cycle(c0 + 2);  check("x_first",    drive_x, 1'b1);
    at_cycle(c0 + 21); check("x_last",     drive_x, 1'b1);
    at_cycle(c0 + 22); check("x_done",     {drive_x, seq_done}, 2'b01);
    at_cycle(c0 + 23); check("x_gatecnt",  gate_count, 32'd1);

    // Single XZ: X 2..21, gap 22..25, Z 26..33, done 34
    wait_idle(100);
    issue(2'b11, c0);
    at_cycle(c0 + 21); check("xz_x_last",  {drive_x, drive_z}, 2'b10);
    at_cycle(c0 + 22); check("xz_gap_a",   {drive_x, drive_z}, 2'b00);
    at_cycle(c0 + 25); check("xz_gap_b",   {drive_x, drive_z}, 2'b00);
    at_cycle(c0 + 26); check("xz_z_first", {drive_x, drive_z}, 2'b01);
    at_cycle(c0 + 33); check("xz_z_last",  {drive_x, drive_z}, 2'b01);
    at_cycle(c0 + 34); check("xz_done",    {drive_z, seq_done}, 2'b01);
    at_cycle(c0 + 35); check("xz_gatecnt", gate_count, 32'd2);

    // Six back-to-back strobes into a depth-4 FIFO: the sixth is dropped
    wait_idle(100);
    pulse_clr();
    ovf_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk_1g); #1;
      apply_gate = 1'b1;
      pauli_gate = seq6[i];
    end
    @(posedge clk_1g); #1 apply_gate = 1'b0;
    wait_idle(400);
    check("burst_drop",  drop_count, 32'd1);
    check("burst_gate",  gate_count, 32'd5);
    check("burst_ovf_pulses", ovf_seen, 1);

    // teleport_fail high 5, low 3, high 2 -> two rising edges
    pulse_clr();
    @(posedge clk_1g); #1 teleport_fail = 1'b1;
    repeat (5) @(posedge clk_1g);
    #1 teleport_fail = 1'b0;
    repeat (3) @(posedge clk_1g);
    #1 teleport_fail = 1'b1;
    repeat (2) @(posedge clk_1g);
    #1 teleport_fail = 1'b0;
    repeat (4) @(posedge clk_1g);
    @(negedge clk_1g); check("fail_two_edges", fail_count, 32'd2);

    // clr_counts in the cycle the fail increment would land
    @(posedge clk_1g); #1 teleport_fail = 1'b1;
    @(posedge clk_1g); #1 clr_counts = 1'b1;
    @(posedge clk_1g); #1 clr_counts = 1'b0;
    @(negedge clk_1g); check("clr_overrides_inc", fail_count, 32'd0);
    @(posedge clk_1g); #1 teleport_fail = 1'b0;

    // Reset during drive_z of XZ with a second command queued
    issue(2'b00, c0);
    wait_idle(100);
    issue(2'b11, c0);
    @(posedge clk_1g); #1;
    apply_gate = 1'b1; pauli_gate = 2'b01;
    @(posedge clk_1g); #1 apply_gate = 1'b0;
    at_cycle(c0 + 28);
    check("rst_pre_z", drive_z, 1'b1);
    check("rst_pre_gate", gate_count, 32'd1);
    @(posedge clk_1g); #1 rst_n = 1'b0;
    #1;
    check("rst_drives_low", {drive_x, drive_z}, 2'b00);
    check("rst_counts_zero", {gate_count, drop_count, fail_count}, '0);
    repeat (2) @(posedge clk_1g);
    #1 rst_n = 1'b1;
    @(negedge clk_1g); check("rst_busy_after", seq_busy, 1'b0);
    repeat (3) @(negedge clk_1g);
    check("rst_queue_lost", {seq_busy, drive_x, drive_z}, 3'b000);

    repeat (2) @(posedge clk_1g);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pauli_pulse_sequencer.md
# pauli_pulse_sequencer

Downstream stage of the quantum-classical interface buffer: consumes its one-cycle `apply_gate` / `pauli_gate` correction commands and turns each into timed X and Z drive windows for Bob's qubit controller. Commands are queued in a small FIFO so back-to-back corrections are never lost while a pulse is in flight. Per-run statistics (gates applied, commands dropped, decoherence failures) are kept for the Instaweb telemetry path.

## Interface
- `X_LEN`, 20: X-pulse length in clk_1g cycles (≥1).
- `Z_LEN`, 8: Z-pulse length in cycles (≥1).
- `GAP_LEN`, 4: idle cycles between X and Z for XZ (≥1).
- `FIFO_DEPTH`, 4: command queue entries (power of two, ≥2).
- `CNT_WIDTH`, 32: statistics counter width.

- `clk_1g`  in  1  1 GHz clock.
- `rst_n`  in  1  Reset, asynchronous, active-low.
- `pauli_gate`  in  2  Correction code: 00=I, 01=X, 10=Z, 11=XZ.
- `apply_gate`  in  1  One-cycle command strobe; `pauli_gate` valid in the same cycle.
- `teleport_fail`  in  1  Failure flag from the upstream buffer (level).
- `clr_counts`  in  1  Synchronous clear of all counters.
- `drive_x`  out  1  X drive window.
- `drive_z`  out  1  Z drive window.
- `seq_busy`  out  1  High when state ≠ IDLE or FIFO non-empty.
- `seq_done`  out  1  One-cycle pulse per completed command.
- `seq_overflow`  out  1  One-cycle pulse when a command is dropped.
- `gate_count`  out  CNT_WIDTH  Completed commands, including I.
- `drop_count`  out  CNT_WIDTH  Dropped commands.
- `fail_count`  out  CNT_WIDTH  Rising edges of `teleport_fail`.

## Operation
- Reset: FIFO empty, state IDLE, every output 0, all counters 0, `teleport_fail` edge register 0.
- Push: `apply_gate`=1 writes `pauli_gate` into the FIFO if it is not full, or if a pop occurs in the same cycle.
- Drop: `apply_gate`=1 when full and no pop occurs: command discarded, `seq_overflow`=1 next cycle, `drop_count`+1.
- FSM states: IDLE, X_PULSE, GAP, Z_PULSE, DONE.
  - IDLE with FIFO non-empty: pop head. Code 00→DONE, 01→X_PULSE, 10→Z_PULSE, 11→X_PULSE.
  - X_PULSE holds X_LEN cycles, then goes to GAP for code 11, otherwise DONE.
  - GAP holds GAP_LEN cycles, then Z_PULSE.
  - Z_PULSE holds Z_LEN cycles, then DONE.
  - DONE lasts 1 cycle, then IDLE. The current code is held in a register for the duration of the command.
- Duration timer: down-counter loaded with len−1 on state entry; the state advances when the counter is 0. Counter width is clog2 of max(X_LEN, Z_LEN, GAP_LEN), minimum 1.
- Outputs:
  - `drive_x` = (state==X_PULSE); `drive_z` = (state==Z_PULSE). Both are decoded from the state register only, so they are glitch-free.
  - `drive_x` and `drive_z` are never high together.
  - `seq_done` = (state==DONE).
- Counters:
  - `gate_count` increments in DONE.
  - `fail_count` increments on a 0→1 transition of registered `teleport_fail`.
  - All counters saturate at all-ones.
  - `clr_counts` zeroes all counters and overrides a same-cycle increment.
- FIFO pointers wrap modulo FIFO_DEPTH. A full/empty extra bit distinguishes the two when the pointers are equal.

## Timing
- Cycle numbering: `apply_gate` high in cycle 0 with an empty FIFO and state IDLE.
  - Entry visible cycle 1; pop and transition at end of cycle 1.
  - Code 01: `drive_x` high cycles 2..X_LEN+1; `seq_done` high cycle X_LEN+2.
  - Code 10: `drive_z` high cycles 2..Z_LEN+1; `seq_done` high cycle Z_LEN+2.
  - Code 11: `drive_x` cycles 2..X_LEN+1; gap X_LEN+2..X_LEN+GAP_LEN+1; `drive_z` X_LEN+GAP_LEN+2..X_LEN+GAP_LEN+Z_LEN+1; `seq_done` the next cycle.
  - Code 00: `seq_done` high cycle 2, no drive.
- Queued commands: the next command is popped in the IDLE cycle after DONE, so consecutive commands are separated by DONE plus IDLE (2 cycles).
- Reset mid-pulse: `drive_x` and `drive_z` drop asynchronously; queued commands are lost.

## Test plan
- Single X (01), default parameters → `drive_x` high cycles 2–21, `seq_done` at 22, `gate_count`=1.
- Single XZ (11) → `drive_x` 2–21, both drives low 22–25, `drive_z` 26–33, `seq_done` at 34, no overlap of `drive_x` and `drive_z`.
- Six strobes 1 cycle apart, codes 01,10,11,00,01,10, FIFO_DEPTH=4 → first five executed in order, sixth dropped, one `seq_overflow` pulse, `drop_count`=1, `gate_count`=5 after drain.
- `teleport_fail` high 5 cycles, low 3, high 2 → `fail_count`=2; `clr_counts` on the same cycle as an increment → 0.
- Assert `rst_n` low during `drive_z` of an XZ command → drives low immediately, all counters 0, `seq_busy`=0 after release.
